// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I core controller.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/core_perf_cnt.sv
// Free-running cycle and retired-instruction counters; both stop advancing
// cycles once the core halts and wrap modulo 2^64.
module core_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        retire_i,
  input  logic        halt_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_cnt_o
);

  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;

  assign cycle_d   = halt_i   ? cycle_q   : cycle_q + 64'd1;
  assign instret_d = retire_i ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the non-pipelined RV32I core: owns PC/IR and walks
// FETCH-DECODE-EXECUTE-MEM-WB. Define CORE_CTRL_PERF_CNT_EN for perf counters.
module core_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            dec_load_i,
  input  logic            dec_store_i,
  input  logic            dec_wr_rd_i,
  input  logic            dec_illegal_i,
  input  logic [XLEN-1:0] ex_res_i,
  input  logic [XLEN-1:0] ex_next_pc_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  input  logic            dmem_valid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            rf_we_o,
  output logic [XLEN-1:0] rf_wdata_o,
`ifdef CORE_CTRL_PERF_CNT_EN
  output logic [63:0]     cycle_cnt_o,
  output logic [63:0]     instret_cnt_o,
`endif
  output logic            halt_o
);

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            fetch_req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      res_q     <= '0;
      next_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      res_q     <= res_d;
      next_pc_q <= next_pc_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    res_d      = res_q;
    next_pc_d  = next_pc_q;
    fetch_req  = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    halt_o     = 1'b0;

    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        if (imem_valid_i) begin
          instr_d = imem_rdata_i;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        res_d     = ex_res_i;
        next_pc_d = ex_next_pc_i;
        if (dec_illegal_i || (ex_next_pc_i[1:0] != 2'b00)) begin
          state_d = HALT;
        end else if (dec_load_i || dec_store_i) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_store_i;
        if (dmem_valid_i) begin
          if (dec_store_i) begin
            pc_d    = next_pc_q;
            state_d = FETCH;
          end else begin
            res_d   = dmem_rdata_i;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we_o = dec_wr_rd_i;
        pc_d    = next_pc_q;
        state_d = FETCH;
      end
      HALT: halt_o = 1'b1;
      default: begin
        halt_o  = 1'b1;
        state_d = HALT;
      end
    endcase
  end

  // Reset parks the FSM in FETCH; the request must still be low while held.
  assign imem_req_o  = fetch_req & rst_ni;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign dmem_addr_o = res_q;
  assign rf_wdata_o  = res_q;

`ifdef CORE_CTRL_PERF_CNT_EN
  logic retire;
  assign retire = (state_q == WB) ||
                  ((state_q == MEM) && dmem_valid_i && dec_store_i);

  core_perf_cnt u_perf_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .retire_i      (retire),
    .halt_i        (halt_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o)
  );
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed vector table, halt/reset
// sequences and randomized instructions checked against a transaction model.
module tb_core_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int TXN_BUDGET = 200;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        dec_load_i, dec_store_i, dec_wr_rd_i, dec_illegal_i;
  logic [31:0] ex_res_i, ex_next_pc_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_valid_i;
  logic [31:0] dmem_rdata_i;
  logic        rf_we_o;
  logic [31:0] rf_wdata_o;
  logic        halt_o;
`ifdef CORE_CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt_o, instret_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  core_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_valid_i  (imem_valid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .dec_load_i    (dec_load_i),
    .dec_store_i   (dec_store_i),
    .dec_wr_rd_i   (dec_wr_rd_i),
    .dec_illegal_i (dec_illegal_i),
    .ex_res_i      (ex_res_i),
    .ex_next_pc_i  (ex_next_pc_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_valid_i  (dmem_valid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rf_we_o       (rf_we_o),
    .rf_wdata_o    (rf_wdata_o),
`ifdef CORE_CTRL_PERF_CNT_EN
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o),
`endif
    .halt_o        (halt_o)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic        ill;
    int          iwait;
    int          dwait;
    logic [31:0] instr;
    logic [31:0] ex_res;
    logic [31:0] next_pc;
    logic [31:0] rdata;
    logic        wr_rd;
    int          e_cycles;
    int          e_writes;
    logic [31:0] e_wdata;
    int          e_dreq;
    logic        e_halt;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] prev_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: cycle count, writeback and memory usage of one
  // instruction derived from the latency rules and halt conditions.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_halt   = v.ill || (v.next_pc[1:0] != 2'b00);
    r.e_dreq   = 0;
    r.e_writes = 0;
    r.e_wdata  = '0;
    r.e_cycles = (v.iwait + 1) + 1 + 1;
    if (!r.e_halt) begin
      if (v.ld || v.st) begin
        r.e_dreq   = v.dwait + 1;
        r.e_cycles = r.e_cycles + v.dwait + 1;
      end
      if (!v.st) begin
        r.e_cycles = r.e_cycles + 1;
        r.e_writes = v.wr_rd ? 1 : 0;
        r.e_wdata  = v.ld ? v.rdata : v.ex_res;
      end
    end
    return r;
  endfunction

  // Acts as memory and decoder for one instruction; entered and left in the
  // middle of the first cycle of a FETCH.
  task automatic run_txn(input vec_t v);
    int          c = 0;
    int          iw = 0;
    int          dw = 0;
    int          writes = 0;
    int          wcyc = 0;
    int          dreq = 0;
    logic        fetched = 1'b0;
    logic        done = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] pc_after;
`ifdef CORE_CTRL_PERF_CNT_EN
    logic [63:0] cyc0 = cycle_cnt_o;
    logic [63:0] ret0 = instret_cnt_o;
`endif
    dec_load_i    = v.ld;
    dec_store_i   = v.st;
    dec_illegal_i = v.ill;
    dec_wr_rd_i   = v.wr_rd;
    ex_res_i      = v.ex_res;
    ex_next_pc_i  = v.next_pc;
    while (!done && c < TXN_BUDGET) begin
      #1;
      c++;
      if (halt_o || (fetched && imem_req_o)) begin
        done = 1'b1;
      end else begin
        if (imem_req_o) begin
          check("imem_addr", imem_addr_o, exp_pc);
          check("instr_hold", instr_o, prev_instr);
          imem_valid_i = (iw == v.iwait);
          imem_rdata_i = (iw == v.iwait) ? v.instr : $urandom;
          fetched      = (iw == v.iwait);
          iw++;
        end else begin
          imem_valid_i = 1'($urandom_range(0, 1));
          imem_rdata_i = $urandom;
        end
        if (dmem_req_o) begin
          check("dmem_addr", dmem_addr_o, v.ex_res);
          check("dmem_we", 32'(dmem_we_o), 32'(v.st));
          dreq++;
          dmem_valid_i = (dw == v.dwait);
          dmem_rdata_i = (dw == v.dwait) ? v.rdata : $urandom;
          dw++;
        end else begin
          dmem_valid_i = 1'b0;
          dmem_rdata_i = $urandom;
        end
        if (rf_we_o) begin
          writes++;
          wdata = rf_wdata_o;
          wcyc  = c;
        end
        @(negedge clk_i);
      end
    end
    imem_valid_i = 1'b0;
    dmem_valid_i = 1'b0;
    check("txn_done", 32'(done), 32'd1);
    check("cycles", c - 1, v.e_cycles);
    check("rf_writes", writes, v.e_writes);
    if (v.e_writes > 0) begin
      check("rf_wdata", wdata, v.e_wdata);
      check("rf_we_cycle", wcyc, v.e_cycles);
    end
    check("dmem_cycles", dreq, v.e_dreq);
    check("halt", 32'(halt_o), 32'(v.e_halt));
    check("instr", instr_o, v.instr);
    pc_after = v.e_halt ? exp_pc : v.next_pc;
    check("pc", pc_o, pc_after);
`ifdef CORE_CTRL_PERF_CNT_EN
    check64("cycle_delta", cycle_cnt_o - cyc0, 64'(c - 1));
    check64("instret_delta", instret_cnt_o - ret0, v.e_halt ? 64'd0 : 64'd1);
`endif
    exp_pc     = pc_after;
    prev_instr = v.instr;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni     = 1'b1;
    exp_pc     = RST_PC;
    prev_instr = '0;
  endtask

  // Halted core must ignore memory responses and hold all state.
  task automatic halt_followup();
`ifdef CORE_CTRL_PERF_CNT_EN
    logic [63:0] cyc0 = cycle_cnt_o;
`endif
    for (int k = 0; k < 5; k++) begin
      imem_valid_i = 1'b1;
      imem_rdata_i = $urandom;
      dmem_valid_i = 1'b1;
      @(negedge clk_i);
      #1;
      check("halt_sticky", 32'(halt_o), 32'd1);
      check("halt_no_imem", 32'(imem_req_o), 32'd0);
      check("halt_no_dmem", 32'(dmem_req_o), 32'd0);
      check("halt_no_rf_we", 32'(rf_we_o), 32'd0);
      check("halt_pc", pc_o, exp_pc);
      check("halt_instr", instr_o, prev_instr);
    end
    imem_valid_i = 1'b0;
    dmem_valid_i = 1'b0;
`ifdef CORE_CTRL_PERF_CNT_EN
    check64("halt_cycle_frozen", cycle_cnt_o, cyc0);
`endif
    do_reset();
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    // ld st ill iwait dwait instr ex_res next_pc rdata wr_rd | cycles writes wdata dreq halt
    tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 32'h0050_0093, 32'h0000_0005, 32'h0000_0104, 32'h0, 1'b1, 4, 1, 32'h0000_0005, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 3, 32'h0000_2083, 32'h0000_2000, 32'h0000_0108, 32'hDEAD_BEEF, 1'b1, 8, 1, 32'hDEAD_BEEF, 4, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 0, 1, 32'h0011_2023, 32'h0000_3000, 32'h0000_010C, 32'h0, 1'b0, 5, 0, 32'h0, 2, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 5, 0, 32'h0020_8133, 32'h0000_0077, 32'h0000_0200, 32'h0, 1'b1, 9, 1, 32'h0000_0077, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 0, 0, 32'h0020_8463, 32'h0000_0001, 32'h0000_0180, 32'h0, 1'b0, 4, 0, 32'h0, 0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1, 0, 32'h0000_2003, 32'h0000_0040, 32'h0000_0184, 32'h1234_5678, 1'b0, 6, 0, 32'h0, 1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 2, 0, 32'h0011_2223, 32'h0000_0044, 32'h0000_0188, 32'h0, 1'b1, 6, 0, 32'h0, 1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1, 0, 32'h0000_006F, 32'h0000_0009, 32'h0000_0102, 32'h0, 1'b1, 4, 0, 32'h0, 0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0104, 32'h0, 1'b1, 3, 0, 32'h0, 0, 1'b1};

    imem_valid_i  = 1'b0;
    imem_rdata_i  = '0;
    dmem_valid_i  = 1'b0;
    dmem_rdata_i  = '0;
    dec_load_i    = 1'b0;
    dec_store_i   = 1'b0;
    dec_wr_rd_i   = 1'b0;
    dec_illegal_i = 1'b0;
    ex_res_i      = '0;
    ex_next_pc_i  = '0;

    repeat (2) @(negedge clk_i);
    #1;
    check("rst_imem_req", 32'(imem_req_o), 32'd0);
    check("rst_dmem_req", 32'(dmem_req_o), 32'd0);
    check("rst_dmem_we", 32'(dmem_we_o), 32'd0);
    check("rst_rf_we", 32'(rf_we_o), 32'd0);
    check("rst_halt", 32'(halt_o), 32'd0);
    check("rst_pc", pc_o, RST_PC);
    check("rst_imem_addr", imem_addr_o, RST_PC);
    check("rst_instr", instr_o, 32'd0);
    check("rst_res", rf_wdata_o, 32'd0);
    check("rst_dmem_addr", dmem_addr_o, 32'd0);
`ifdef CORE_CTRL_PERF_CNT_EN
    check64("rst_cycle_cnt", cycle_cnt_o, 64'd0);
    check64("rst_instret_cnt", instret_cnt_o, 64'd0);
`endif
    @(negedge clk_i);
    rst_ni     = 1'b1;
    exp_pc     = RST_PC;
    prev_instr = '0;

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i]);
      if (tbl[i].e_halt) halt_followup();
    end

    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [31:0] npc;
      k          = $urandom_range(0, 2);
      v.ld       = (k == 1);
      v.st       = (k == 2);
      v.ill      = ($urandom_range(0, 11) == 0);
      v.iwait    = $urandom_range(0, 3);
      v.dwait    = $urandom_range(0, 3);
      v.instr    = $urandom;
      v.ex_res   = $urandom;
      npc        = $urandom;
      npc[1:0]   = ($urandom_range(0, 11) == 0) ? 2'b10 : 2'b00;
      v.next_pc  = npc;
      v.rdata    = $urandom;
      v.wr_rd    = 1'($urandom_range(0, 1));
      v = model(v);
      run_txn(v);
      if (v.e_halt) halt_followup();
    end

    // Asynchronous reset while a load waits on data memory.
    begin
      int   c = 0;
      logic in_mem = 1'b0;
      dec_load_i    = 1'b1;
      dec_store_i   = 1'b0;
      dec_illegal_i = 1'b0;
      dec_wr_rd_i   = 1'b1;
      ex_res_i      = 32'h0000_5000;
      ex_next_pc_i  = 32'h0000_0300;
      while (!in_mem && c < 20) begin
        #1;
        c++;
        in_mem       = dmem_req_o;
        imem_valid_i = imem_req_o;
        imem_rdata_i = 32'h0000_2283;
        dmem_valid_i = 1'b0;
        if (!in_mem) @(negedge clk_i);
      end
      check("mem_reached", 32'(in_mem), 32'd1);
      repeat (2) @(negedge clk_i);
      #1;
      check("mem_req_held", 32'(dmem_req_o), 32'd1);
      check("mem_addr_held", dmem_addr_o, 32'h0000_5000);
      rst_ni = 1'b0;
      #1;
      check("arst_dmem_req", 32'(dmem_req_o), 32'd0);
      check("arst_imem_req", 32'(imem_req_o), 32'd0);
      check("arst_pc", pc_o, RST_PC);
      check("arst_instr", instr_o, 32'd0);
`ifdef CORE_CTRL_PERF_CNT_EN
      check64("arst_cycle_cnt", cycle_cnt_o, 64'd0);
      check64("arst_instret_cnt", instret_cnt_o, 64'd0);
`endif
      @(negedge clk_i);
      dmem_valid_i = 1'b1;
      @(negedge clk_i);
      dmem_valid_i = 1'b0;
      rst_ni       = 1'b1;
      exp_pc       = RST_PC;
      prev_instr   = '0;
      run_txn(tbl[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle sequencer for the non-pipelined RV32I core.
- Owns the PC and instruction registers.
- Sequences fetch, decode, execute, memory access and register-file writeback around the combinational execute datapath.
- Issues single-outstanding requests to instruction and data memory; halts on illegal instruction or misaligned next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- imem_req_o  out  1  instruction fetch request
- imem_addr_o  out  32  fetch address (= pc_o)
- imem_valid_i  in  1  fetch data valid, completes the request
- imem_rdata_i  in  32  fetched instruction
- instr_o  out  32  latched instruction register, feeds decoder
- pc_o  out  32  current PC, feeds execute
- dec_load_i / dec_store_i  in  1  decoded load / store
- dec_wr_rd_i  in  1  instruction writes rd (rd != x0 qualified by decoder)
- dec_illegal_i  in  1  decoder flags illegal encoding
- ex_res_i  in  32  execute result (ALU result, address, or link value)
- ex_next_pc_i  in  32  execute next-PC
- dmem_req_o  out  1  data request
- dmem_we_o  out  1  1 = store, 0 = load
- dmem_addr_o  out  32  registered data address
- dmem_valid_i  in  1  data access complete
- dmem_rdata_i  in  32  load data, already extended by the memory interface
- rf_we_o  out  1  register-file write enable, 1-cycle pulse
- rf_wdata_o  out  32  writeback data
- halt_o  out  1  core halted, sticky until reset

Behaviour:
- Reset (async assert, sync release) drives:
  - pc = RESET_PC, instr = 0, state = FETCH
  - res_q = 0, next_pc_q = 0, all req/we outputs 0, halt_o = 0
- FETCH:
  - imem_req_o = 1, imem_addr_o = pc.
  - Request stays asserted, address stable, until imem_valid_i.
  - On imem_valid_i: instr <= imem_rdata_i, go to DECODE.
  - imem_valid_i outside FETCH is ignored.
- DECODE: one cycle for register-file read; then EXECUTE.
- EXECUTE: one cycle.
  - res_q <= ex_res_i, next_pc_q <= ex_next_pc_i.
  - dec_illegal_i = 1, or ex_next_pc_i[1:0] != 0: go to HALT.
  - Otherwise load or store: go to MEM. Else: go to WB.
- MEM:
  - dmem_req_o = 1, dmem_addr_o = res_q, dmem_we_o = dec_store_i.
  - Held stable until dmem_valid_i.
  - On completion, load: res_q <= dmem_rdata_i, go to WB.
  - On completion, store: pc <= next_pc_q, go to FETCH.
- WB: one cycle.
  - rf_we_o = dec_wr_rd_i, rf_wdata_o = res_q, pc <= next_pc_q, go to FETCH.
- HALT: terminal state.
  - halt_o = 1, no requests, pc and instr frozen, only reset leaves.
- rf_wdata_o equals res_q in all states; rf_we_o is asserted only in WB.
- Latency with zero-wait memory, where N = memory wait cycles:
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load: 5 + N cycles.
  - Store: 4 + N cycles.
- The decoder must keep dec_* stable from DECODE through WB; instr is unchanged until the next FETCH completes.
- Reset mid-transaction: requests drop immediately; the memory side must discard any in-flight response.
- Unused state encodings go to HALT.

Optional Feature:
- Macro: CORE_CTRL_PERF_CNT_EN.
- When defined, add 64-bit outputs cycle_cnt_o and instret_cnt_o, both reset to 0.
  - cycle_cnt_o increments every cycle except in HALT.
  - instret_cnt_o increments on each retire: the WB exit, or store completion in MEM.
  - Both wrap modulo 2^64.
- When not defined, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - state enum ctrl_state_e: FETCH, DECODE, EXECUTE, MEM, WB, HALT
  - RESET_PC default constant
  - XLEN = 32
- Natural sub-module: core_perf_cnt (the two counters, retire and halt inputs), instantiated only under CORE_CTRL_PERF_CNT_EN.

Test Plan:
- ALU op, zero-wait memory:
  - Stimulus: reset with RESET_PC = 0x100; imem returns addi; ex_res = 5, ex_next_pc = 0x104, dec_wr_rd = 1.
  - Response: rf_we pulse with wdata 5 on cycle 4; pc = 0x104; imem_req reasserts on cycle 5.
- Load with 3-cycle dmem wait:
  - Stimulus: dec_load = 1, ex_res = 0x2000, dmem_rdata = 0xDEADBEEF.
  - Response: dmem_req held 4 cycles with addr 0x2000 and we = 0; rf_wdata = 0xDEADBEEF; retire on cycle 8.
- Store:
  - Stimulus: dec_store = 1.
  - Response: dmem_we = 1; no rf_we; pc <= next_pc at dmem_valid; back to FETCH.
- Fetch stall:
  - Stimulus: imem_valid delayed 5 cycles.
  - Response: imem_req and imem_addr stable throughout; instr changes only on the valid cycle.
- Halt cases:
  - Stimulus: dec_illegal = 1, or ex_next_pc = 0x102.
  - Response: halt_o = 1 from the cycle after EXECUTE; no further req or rf_we; pc frozen.
- Async reset:
  - Stimulus: rst_ni low during MEM.
  - Response: dmem_req drops same cycle; pc = RESET_PC; with CORE_CTRL_PERF_CNT_EN, both counters read 0.
